// File: rtl/superscalar_pkg.sv
// Shared opcode constants, issue FSM state type and pair-hazard helpers for the dual-issue front end.
// The optional statistics counters in issue_ctrl are enabled with the ISSUE_STATS_EN macro.
package superscalar_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_OP     = 7'b0110011;

   // addi x0,x0,0 : driven on every lane that carries nothing
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          STAT_W    = 32;

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FULL   = 2'd1,
      SECOND = 2'd2
   } issue_state_t;

   function automatic logic writes_rd(input logic [31:0] instr);
      return (instr[6:0] != OP_STORE) && (instr[6:0] != OP_BRANCH) && (instr[11:7] != 5'd0);
   endfunction

   function automatic logic is_mem(input logic [6:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/pair_hazard_check.sv
// Combinational intra-pair hazard detector: decides whether the younger slot must wait
// one cycle behind the older slot. Individual hazard causes are exposed for debug.
module pair_hazard_check
   import superscalar_pkg::*;
(
   input  logic [31:0] i_instr1,
   input  logic [31:0] i_instr2,
   output logic        split_o,
   output logic        raw_o,
   output logic        waw_o,
   output logic        mem_o,
   output logic        ctl_o
);

   logic [6:0] w_op1;
   logic [6:0] w_op2;
   logic [4:0] w_rd1;
   logic [4:0] w_rd2;
   logic [4:0] w_rs1_2;
   logic [4:0] w_rs2_2;
   logic       w_wr1;
   logic       w_wr2;
   logic       w_reads_rs1;
   logic       w_reads_rs2;
   logic       w_unused;

   assign w_op1   = i_instr1[6:0];
   assign w_op2   = i_instr2[6:0];
   assign w_rd1   = i_instr1[11:7];
   assign w_rd2   = i_instr2[11:7];
   assign w_rs1_2 = i_instr2[19:15];
   assign w_rs2_2 = i_instr2[24:20];

   // writes_rd already excludes x0, so x0 can never create a RAW or WAW hazard
   assign w_wr1 = writes_rd(i_instr1);
   assign w_wr2 = writes_rd(i_instr2);

   assign w_reads_rs1 = (w_op2 != OP_LUI) && (w_op2 != OP_AUIPC) && (w_op2 != OP_JAL);
   assign w_reads_rs2 = (w_op2 == OP_OP) || (w_op2 == OP_STORE) || (w_op2 == OP_BRANCH);

   assign raw_o = w_wr1 && ((w_reads_rs1 && (w_rs1_2 == w_rd1)) ||
                            (w_reads_rs2 && (w_rs2_2 == w_rd1)));
   assign waw_o = w_wr1 && w_wr2 && (w_rd1 == w_rd2);
   assign mem_o = is_mem(w_op1) && is_mem(w_op2);
   assign ctl_o = (w_op1 == OP_BRANCH) || (w_op1 == OP_JAL) || (w_op1 == OP_JALR);

   assign split_o = raw_o || waw_o || mem_o || ctl_o;

   assign w_unused = ^{i_instr1[31:12], i_instr2[31:25], i_instr2[14:12]};

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: holds one fetched pair, issues it whole or split over two cycles.
// Define ISSUE_STATS_EN to add the dual/split/stall statistics counters and their ports.
module issue_ctrl
   import superscalar_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               fetch_valid_i,
   input  logic               fetch_valid2_i,
   input  logic [31:0]        fetch_instr1_i,
   input  logic [31:0]        fetch_instr2_i,
   input  logic [31:0]        fetch_pc1_i,
   input  logic [31:0]        fetch_pc2_i,
   output logic               fetch_ready_o,
   input  logic               stall_i,
   input  logic               flush_i,
   output logic [31:0]        InstrD1,
   output logic [31:0]        InstrD2,
   output logic [31:0]        PCD1,
   output logic [31:0]        PCD2,
   output logic               ValidD1,
   output logic               ValidD2,
   output issue_state_t       dbg_state_o,
   output logic [3:0]         dbg_hazard_o
`ifdef ISSUE_STATS_EN
   ,
   output logic [STAT_W-1:0]  stat_dual_o,
   output logic [STAT_W-1:0]  stat_split_o,
   output logic [STAT_W-1:0]  stat_stall_o
`endif
);

   // Handshake: a pair transfers on a rising edge where fetch_valid_i && fetch_ready_o.
   // fetch_ready_o never depends on fetch_valid_i.

   issue_state_t r_state;
   issue_state_t w_state_nxt;
   logic [31:0]  r_instr1;
   logic [31:0]  r_instr2;
   logic [31:0]  r_pc1;
   logic [31:0]  r_pc2;
   logic         r_valid2;

   logic w_hz_split;
   logic w_hz_raw;
   logic w_hz_waw;
   logic w_hz_mem;
   logic w_hz_ctl;
   logic w_split;
   logic w_complete;
   logic w_accept;

   pair_hazard_check u_hazard (
      .i_instr1 (r_instr1),
      .i_instr2 (r_instr2),
      .split_o  (w_hz_split),
      .raw_o    (w_hz_raw),
      .waw_o    (w_hz_waw),
      .mem_o    (w_hz_mem),
      .ctl_o    (w_hz_ctl)
   );

   assign dbg_state_o  = r_state;
   assign dbg_hazard_o = {w_hz_raw, w_hz_waw, w_hz_mem, w_hz_ctl};

   // A pair without a real slot 2 never needs splitting
   assign w_split    = r_valid2 && w_hz_split;
   assign w_complete = !stall_i && !flush_i &&
                       (((r_state == FULL) && !w_split) || (r_state == SECOND));
   assign fetch_ready_o = !stall_i && !flush_i && ((r_state == EMPTY) || w_complete);
   assign w_accept      = fetch_valid_i && fetch_ready_o;

   always_comb begin
      w_state_nxt = r_state;
      if (flush_i) begin
         w_state_nxt = EMPTY;
      end else if (!stall_i) begin
         case (r_state)
            EMPTY:   w_state_nxt = w_accept ? FULL : EMPTY;
            FULL:    w_state_nxt = w_split ? SECOND : (w_accept ? FULL : EMPTY);
            SECOND:  w_state_nxt = w_accept ? FULL : EMPTY;
            default: w_state_nxt = EMPTY;
         endcase
      end
   end

   always_comb begin
      ValidD1 = 1'b0;
      ValidD2 = 1'b0;
      InstrD1 = NOP_INSTR;
      InstrD2 = NOP_INSTR;
      PCD1    = r_pc1;
      PCD2    = r_pc2;
      case (r_state)
         FULL: begin
            ValidD1 = 1'b1;
            InstrD1 = r_instr1;
            if (!w_split) begin
               ValidD2 = r_valid2;
               InstrD2 = r_valid2 ? r_instr2 : NOP_INSTR;
            end
         end
         SECOND: begin
            // the younger instruction moves to lane 1 so lane 1 stays oldest
            ValidD1 = 1'b1;
            InstrD1 = r_instr2;
            PCD1    = r_pc2;
         end
         default: ;
      endcase
      if (flush_i) begin
         ValidD1 = 1'b0;
         ValidD2 = 1'b0;
         InstrD1 = NOP_INSTR;
         InstrD2 = NOP_INSTR;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= EMPTY;
         r_instr1 <= NOP_INSTR;
         r_instr2 <= NOP_INSTR;
         r_pc1    <= 32'd0;
         r_pc2    <= 32'd0;
         r_valid2 <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (flush_i) begin
            r_instr1 <= NOP_INSTR;
            r_instr2 <= NOP_INSTR;
            r_pc1    <= 32'd0;
            r_pc2    <= 32'd0;
            r_valid2 <= 1'b0;
         end else if (w_accept) begin
            r_instr1 <= fetch_instr1_i;
            r_instr2 <= fetch_valid2_i ? fetch_instr2_i : NOP_INSTR;
            r_pc1    <= fetch_pc1_i;
            r_pc2    <= fetch_pc2_i;
            r_valid2 <= fetch_valid2_i;
         end
      end
   end

`ifdef ISSUE_STATS_EN
   logic [STAT_W-1:0] r_stat_dual;
   logic [STAT_W-1:0] r_stat_split;
   logic [STAT_W-1:0] r_stat_stall;

   // Counters wrap naturally; flush cycles are never counted
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_dual  <= '0;
         r_stat_split <= '0;
         r_stat_stall <= '0;
      end else if (!flush_i) begin
         if (!stall_i && (r_state == FULL) && !w_split && r_valid2)
            r_stat_dual <= r_stat_dual + 1'b1;
         if (!stall_i && (r_state == FULL) && w_split)
            r_stat_split <= r_stat_split + 1'b1;
         if (stall_i && (r_state != EMPTY))
            r_stat_stall <= r_stat_stall + 1'b1;
      end
   end

   assign stat_dual_o  = r_stat_dual;
   assign stat_split_o = r_stat_split;
   assign stat_stall_o = r_stat_stall;
`endif

endmodule

// File: tb/tb_issue_ctrl.sv
// Testbench for issue_ctrl: directed scenarios plus randomized traffic against a queue-based model.
// Statistics checks are compiled in when ISSUE_STATS_EN is defined.
module tb_issue_ctrl;
   import superscalar_pkg::issue_state_t;
   import superscalar_pkg::EMPTY;
   import superscalar_pkg::FULL;
   import superscalar_pkg::SECOND;

   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_BRANCH = 7'b1100011;
   localparam logic [6:0] T_JAL = 7'b1101111, T_JALR = 7'b1100111, T_LUI = 7'b0110111;
   localparam logic [6:0] T_AUIPC = 7'b0010111, T_OP = 7'b0110011, T_OPIMM = 7'b0010011;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic fetch_valid_i = 1'b0, fetch_valid2_i = 1'b0;
   logic [31:0] fetch_instr1_i = NOP, fetch_instr2_i = NOP, fetch_pc1_i = '0, fetch_pc2_i = '0;
   logic stall_i = 1'b0, flush_i = 1'b0;
   logic fetch_ready_o, ValidD1, ValidD2;
   logic [31:0] InstrD1, InstrD2, PCD1, PCD2;
   issue_state_t dbg_state_o;
   logic [3:0] dbg_hazard_o;
`ifdef ISSUE_STATS_EN
   logic [31:0] stat_dual_o, stat_split_o, stat_stall_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed { logic [31:0] instr; logic [31:0] pc; } slot_t;
   slot_t mq[$];

   issue_ctrl dut (
      .clk(clk), .rst(rst),
      .fetch_valid_i(fetch_valid_i), .fetch_valid2_i(fetch_valid2_i),
      .fetch_instr1_i(fetch_instr1_i), .fetch_instr2_i(fetch_instr2_i),
      .fetch_pc1_i(fetch_pc1_i), .fetch_pc2_i(fetch_pc2_i),
      .fetch_ready_o(fetch_ready_o), .stall_i(stall_i), .flush_i(flush_i),
      .InstrD1(InstrD1), .InstrD2(InstrD2), .PCD1(PCD1), .PCD2(PCD2),
      .ValidD1(ValidD1), .ValidD2(ValidD2),
      .dbg_state_o(dbg_state_o), .dbg_hazard_o(dbg_hazard_o)
`ifdef ISSUE_STATS_EN
      , .stat_dual_o(stat_dual_o), .stat_split_o(stat_split_o), .stat_stall_o(stat_stall_o)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached (got running, required finished)");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic v2, input logic [31:0] i1, input logic [31:0] i2,
                        input logic [31:0] p1, input logic [31:0] p2);
      fetch_valid_i  = v;
      fetch_valid2_i = v2;
      fetch_instr1_i = i1;
      fetch_instr2_i = i2;
      fetch_pc1_i    = p1;
      fetch_pc2_i    = p2;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, NOP, NOP, 32'd0, 32'd0);
   endtask

   // reference model: split rules taken straight from the pairing rules
   function automatic bit m_split(input logic [31:0] a, input logic [31:0] b);
      logic [6:0] oa, ob;
      bit a_wr, b_wr, b_r1, b_r2, raw, waw, mem, ctl;
      oa = a[6:0];
      ob = b[6:0];
      a_wr = (oa != T_STORE) && (oa != T_BRANCH) && (a[11:7] != 5'd0);
      b_wr = (ob != T_STORE) && (ob != T_BRANCH) && (b[11:7] != 5'd0);
      b_r1 = !((ob == T_LUI) || (ob == T_AUIPC) || (ob == T_JAL));
      b_r2 = (ob == T_OP) || (ob == T_STORE) || (ob == T_BRANCH);
      raw  = a_wr && ((b_r1 && b[19:15] == a[11:7]) || (b_r2 && b[24:20] == a[11:7]));
      waw  = a_wr && b_wr && (a[11:7] == b[11:7]);
      mem  = ((oa == T_LOAD) || (oa == T_STORE)) && ((ob == T_LOAD) || (ob == T_STORE));
      ctl  = (oa == T_BRANCH) || (oa == T_JAL) || (oa == T_JALR);
      return raw || waw || mem || ctl;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] op;
      case ($urandom_range(0, 8))
         0: op = T_LOAD;   1: op = T_STORE; 2: op = T_BRANCH;
         3: op = T_JAL;    4: op = T_JALR;  5: op = T_LUI;
         6: op = T_AUIPC;  7: op = T_OP;    default: op = T_OPIMM;
      endcase
      return {7'($urandom_range(0, 127)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)), op};
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      idle();
      tick();
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o} !== 3'b001) begin
         n_err++;
         $display("FAIL reset_flags: got V1V2R=%b%b%b, required 001", ValidD1, ValidD2, fetch_ready_o);
      end
      n_cmp++;
      if ({InstrD1, InstrD2} !== {NOP, NOP}) begin
         n_err++;
         $display("FAIL reset_instr: got %h/%h, required %h/%h", InstrD1, InstrD2, NOP, NOP);
      end
      n_cmp++;
      if ({PCD1, PCD2} !== 64'd0) begin
         n_err++;
         $display("FAIL reset_pc: got %h/%h, required 0/0", PCD1, PCD2);
      end
      n_cmp++;
      if (dbg_state_o !== EMPTY) begin
         n_err++;
         $display("FAIL reset_state: got %0d, required EMPTY", dbg_state_o);
      end
   endtask

   task automatic test_dual();
      tick();
      drive(1'b1, 1'b1, 32'h00100093, 32'h00200113, 32'h100, 32'h104);
      #1;
      n_cmp++;
      if (fetch_ready_o !== 1'b1) begin
         n_err++;
         $display("FAIL dual_ready0: got %b, required 1", fetch_ready_o);
      end
      tick();
      drive(1'b1, 1'b1, 32'h00500013, 32'h000001B3, 32'h108, 32'h10C);
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, PCD1, PCD2} !==
          {3'b111, 32'h00100093, 32'h00200113, 32'h100, 32'h104}) begin
         n_err++;
         $display("FAIL dual_first: got V=%b%b R=%b %h/%h pc %h/%h, required V=11 R=1 00100093/00200113 pc 100/104",
                  ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, PCD1, PCD2);
      end
      tick();
      idle();
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, InstrD1, InstrD2, PCD2} !== {2'b11, 32'h00500013, 32'h000001B3, 32'h10C}) begin
         n_err++;
         $display("FAIL dual_x0: got V=%b%b %h/%h pc2 %h, required V=11 00500013/000001b3 pc2 10c",
                  ValidD1, ValidD2, InstrD1, InstrD2, PCD2);
      end
      tick();
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o} !== 3'b001) begin
         n_err++;
         $display("FAIL dual_drain: got V1V2R=%b%b%b, required 001", ValidD1, ValidD2, fetch_ready_o);
      end
   endtask

   task automatic split_pair(input string name, input logic [31:0] i1, input logic [31:0] i2,
                             input logic [31:0] p1);
      tick();
      drive(1'b1, 1'b1, i1, i2, p1, p1 + 32'd4);
      #1;
      tick();
      idle();
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, PCD1} !== {3'b100, i1, NOP, p1}) begin
         n_err++;
         $display("FAIL %s_cycle1: got V=%b%b R=%b %h/%h pc1 %h, required V=10 R=0 %h/%h pc1 %h",
                  name, ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, PCD1, i1, NOP, p1);
      end
      tick();
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, PCD1} !== {3'b101, i2, NOP, p1 + 32'd4}) begin
         n_err++;
         $display("FAIL %s_cycle2: got V=%b%b R=%b %h/%h pc1 %h, required V=10 R=1 %h/%h pc1 %h",
                  name, ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, PCD1, i2, NOP, p1 + 32'd4);
      end
      tick();
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o} !== 3'b001) begin
         n_err++;
         $display("FAIL %s_drain: got V1V2R=%b%b%b, required 001", name, ValidD1, ValidD2, fetch_ready_o);
      end
   endtask

   task automatic test_raw_split();
      split_pair("raw", 32'h00100093, 32'h001081B3, 32'h200);
`ifdef ISSUE_STATS_EN
      n_cmp++;
      if ({stat_dual_o, stat_split_o} !== {32'd2, 32'd1}) begin
         n_err++;
         $display("FAIL stats_after_split: got dual=%0d split=%0d, required dual=2 split=1",
                  stat_dual_o, stat_split_o);
      end
`endif
   endtask

   task automatic test_mem_split();
      split_pair("mem", 32'h00012283, 32'h00612223, 32'h300);
   endtask

   task automatic test_flush();
      tick();
      drive(1'b1, 1'b1, 32'h00100093, 32'h001081B3, 32'h400, 32'h404);
      #1;
      tick();
      idle();
      #1;
      tick();
      #1;
      n_cmp++;
      if (dbg_state_o !== SECOND || InstrD1 !== 32'h001081B3) begin
         n_err++;
         $display("FAIL flush_pre: got state=%0d I1=%h, required SECOND 001081b3", dbg_state_o, InstrD1);
      end
      flush_i = 1'b1;
      drive(1'b1, 1'b1, 32'h00200113, 32'h00300193, 32'h500, 32'h504);
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o, InstrD1} !== {3'b000, NOP}) begin
         n_err++;
         $display("FAIL flush_same: got V=%b%b R=%b I1=%h, required V=00 R=0 I1=%h",
                  ValidD1, ValidD2, fetch_ready_o, InstrD1, NOP);
      end
      tick();
      flush_i = 1'b0;
      idle();
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o} !== 3'b001 || dbg_state_o !== EMPTY) begin
         n_err++;
         $display("FAIL flush_after: got V1V2R=%b%b%b state=%0d, required 001 EMPTY",
                  ValidD1, ValidD2, fetch_ready_o, dbg_state_o);
      end
   endtask

   task automatic test_stall();
      tick();
      drive(1'b1, 1'b1, 32'h00100093, 32'h00200113, 32'h600, 32'h604);
      #1;
      tick();
      stall_i = 1'b1;
      drive(1'b1, 1'b1, 32'h00300193, 32'h00400213, 32'h608, 32'h60C);
      for (int k = 0; k < 3; k++) begin
         #1;
         n_cmp++;
         if ({ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, PCD1, PCD2} !==
             {3'b110, 32'h00100093, 32'h00200113, 32'h600, 32'h604} || dbg_state_o !== FULL) begin
            n_err++;
            $display("FAIL stall_hold%0d: got V=%b%b R=%b %h/%h pc %h/%h state=%0d, required V=11 R=0 00100093/00200113 pc 600/604 FULL",
                     k, ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, PCD1, PCD2, dbg_state_o);
         end
         tick();
      end
      stall_i = 1'b0;
      idle();
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o} !== 3'b111) begin
         n_err++;
         $display("FAIL stall_release: got V1V2R=%b%b%b, required 111", ValidD1, ValidD2, fetch_ready_o);
      end
      tick();
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2} !== 2'b00 || dbg_state_o !== EMPTY) begin
         n_err++;
         $display("FAIL stall_issued: got V=%b%b state=%0d, required V=00 EMPTY", ValidD1, ValidD2, dbg_state_o);
      end
`ifdef ISSUE_STATS_EN
      n_cmp++;
      if (stat_stall_o !== 32'd3) begin
         n_err++;
         $display("FAIL stats_stall: got %0d, required 3", stat_stall_o);
      end
`endif
   endtask

   task automatic test_reset_second();
      tick();
      drive(1'b1, 1'b1, 32'h00012283, 32'h00612223, 32'h700, 32'h704);
      #1;
      tick();
      idle();
      #1;
      tick();
      rst = 1'b1;
      #1;
      tick();
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2} !== {3'b001, NOP, NOP}) begin
         n_err++;
         $display("FAIL reset_second: got V=%b%b R=%b %h/%h, required V=00 R=1 %h/%h",
                  ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, NOP, NOP);
      end
   endtask

   task automatic test_random();
      logic [31:0] pc;
      logic e_v1, e_v2, e_rdy, dual;
      logic [31:0] e_i1, e_i2, e_p1, e_p2;
      slot_t s;
      pc = 32'h1000;
      rst = 1'b1;
      idle();
      tick();
      rst = 1'b0;
      mq.delete();
      for (int c = 0; c < 400; c++) begin
         rst     = ($urandom_range(0, 49) == 0);
         stall_i = ($urandom_range(0, 4) == 0);
         flush_i = ($urandom_range(0, 19) == 0);
         drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, rand_instr(), rand_instr(), pc, pc + 32'd4);
         #1;
         dual  = (mq.size() == 2) && !m_split(mq[0].instr, mq[1].instr);
         e_v1  = 1'b0; e_v2 = 1'b0; e_i1 = NOP; e_i2 = NOP; e_p1 = '0; e_p2 = '0;
         e_rdy = !stall_i && !flush_i && ((mq.size() == 0) || (mq.size() == 1) || dual);
         if (!flush_i && mq.size() != 0) begin
            e_v1 = 1'b1; e_i1 = mq[0].instr; e_p1 = mq[0].pc;
            if (dual) begin
               e_v2 = 1'b1; e_i2 = mq[1].instr; e_p2 = mq[1].pc;
            end
         end
         n_cmp++;
         if ({ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2} !== {e_v1, e_v2, e_rdy, e_i1, e_i2}) begin
            n_err++;
            $display("FAIL rand_lanes c=%0d: got V=%b%b R=%b %h/%h, required V=%b%b R=%b %h/%h",
                     c, ValidD1, ValidD2, fetch_ready_o, InstrD1, InstrD2, e_v1, e_v2, e_rdy, e_i1, e_i2);
         end
         if (e_v1) begin
            n_cmp++;
            if (PCD1 !== e_p1 || (e_v2 && PCD2 !== e_p2)) begin
               n_err++;
               $display("FAIL rand_pc c=%0d: got %h/%h, required %h/%h (lane2 only if valid)",
                        c, PCD1, PCD2, e_p1, e_p2);
            end
         end
         // model update for the coming edge
         if (rst || flush_i) begin
            mq.delete();
         end else if (!stall_i) begin
            if (mq.size() == 2 && !dual) void'(mq.pop_front());
            else mq.delete();
            if (fetch_valid_i && e_rdy) begin
               s.instr = fetch_instr1_i; s.pc = fetch_pc1_i;
               mq.push_back(s);
               if (fetch_valid2_i) begin
                  s.instr = fetch_instr2_i; s.pc = fetch_pc2_i;
                  mq.push_back(s);
               end
               pc = pc + 32'd8;
            end
         end
         tick();
      end
      rst = 1'b0;
      stall_i = 1'b0;
      flush_i = 1'b0;
      idle();
   endtask

   initial begin
      test_reset();
      test_dual();
      test_raw_split();
      test_mem_split();
      test_flush();
      test_stall();
      test_reset_second();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
